// File: rtl/dsp_mac_sequencer.sv
// Streaming multiply-accumulate controller for a DSP slice configured with
// AREG=BREG=MREG=PREG=1 and registered control inputs. Accepts signed (a, b)
// pairs grouped into vectors by a last flag, sequences the slice operand,
// OPMODE and clock-enable pins, and returns each vector's dot product.
module dsp_mac_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [24:0]      i_s_a,
    input  logic [17:0]      i_s_b,
    input  logic             i_s_last,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [47:0]      o_m_data,
    output logic [CNT_W-1:0] o_m_count,
    output logic [29:0]      o_dsp_a,
    output logic [17:0]      o_dsp_b,
    output logic [6:0]       o_dsp_opmode,
    output logic [3:0]       o_dsp_alumode,
    output logic [4:0]       o_dsp_inmode,
    output logic [2:0]       o_dsp_carryinsel,
    output logic             o_dsp_cea2,
    output logic             o_dsp_ceb2,
    output logic             o_dsp_cem,
    output logic             o_dsp_cectrl,
    output logic             o_dsp_cep,
    input  logic [47:0]      i_dsp_p
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // X=M, Y=M, Z=0 starts a new sum; Z=P continues it
    localparam logic [6:0] OPMODE_FIRST = 7'h05;
    localparam logic [6:0] OPMODE_ACC   = 7'h25;

    state_t           r_state;
    state_t           w_next_state;
    logic             w_s_ready;
    logic             w_drain_load;
    logic             w_capture;
    logic             w_xfer;
    logic             w_first;
    logic [1:0]       r_drain_cnt;
    logic [CNT_W-1:0] r_samples;
    logic [47:0]      r_m_data;
    logic [CNT_W-1:0] r_m_count;
    logic [29:0]      r_dsp_a;
    logic [17:0]      r_dsp_b;
    logic [6:0]       r_op_s1;
    logic [6:0]       r_dsp_opmode;
    logic [2:0]       r_vld;

    // Ready is forced low while reset is held so nothing transfers in that cycle
    assign o_s_ready = w_s_ready & ~i_rst;
    assign w_xfer    = i_s_valid & o_s_ready;
    // The only sample accepted in IDLE is the first one of its vector
    assign w_first   = (r_state == IDLE);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the drain-load and result-capture strobes
    always_comb begin
        w_next_state = r_state;
        w_s_ready    = 1'b0;
        w_drain_load = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                w_s_ready = 1'b1;
                if (i_s_valid) begin
                    if (i_s_last) begin
                        w_next_state = DRAIN;
                        w_drain_load = 1'b1;
                    end else begin
                        w_next_state = ACCUM;
                    end
                end
            end
            ACCUM: begin
                w_s_ready = 1'b1;
                if (i_s_valid && i_s_last) begin
                    w_next_state = DRAIN;
                    w_drain_load = 1'b1;
                end
            end
            DRAIN: begin
                if (r_drain_cnt == 2'd0) begin
                    w_next_state = DONE;
                    w_capture    = 1'b1;
                end
            end
            DONE: begin
                if (i_m_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Drain countdown covers the slice latency from the last sample to P
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_drain_cnt <= 2'd0;
        end else if (w_drain_load) begin
            r_drain_cnt <= 2'd3;
        end else if (r_state == DRAIN && r_drain_cnt != 2'd0) begin
            r_drain_cnt <= r_drain_cnt - 2'd1;
        end
    end

    // Per-vector sample counter, restarting at 1 and saturating at all-ones
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_samples <= '0;
        end else if (w_xfer) begin
            if (w_first) begin
                r_samples <= CNT_W'(1);
            end else if (r_samples != {CNT_W{1'b1}}) begin
                r_samples <= r_samples + CNT_W'(1);
            end
        end
    end

    // Result capture once P holds the final accumulation; holds until the next capture
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_m_data  <= '0;
            r_m_count <= '0;
        end else if (w_capture) begin
            r_m_data  <= i_dsp_p;
            r_m_count <= r_samples;
        end
    end

    // Operand/OPMODE pipeline with a valid shift register that paces the stage enables
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dsp_a      <= '0;
            r_dsp_b      <= '0;
            r_op_s1      <= '0;
            r_dsp_opmode <= '0;
            r_vld        <= '0;
        end else begin
            r_vld <= {r_vld[1:0], w_xfer};
            if (w_xfer) begin
                r_dsp_a <= {{5{i_s_a[24]}}, i_s_a};
                r_dsp_b <= i_s_b;
                r_op_s1 <= w_first ? OPMODE_FIRST : OPMODE_ACC;
            end
            if (r_vld[0]) begin
                r_dsp_opmode <= r_op_s1;
            end
        end
    end

    assign o_m_valid        = (r_state == DONE);
    assign o_m_data         = r_m_data;
    assign o_m_count        = r_m_count;
    assign o_dsp_a          = r_dsp_a;
    assign o_dsp_b          = r_dsp_b;
    assign o_dsp_opmode     = r_dsp_opmode;
    assign o_dsp_alumode    = 4'b0000;
    assign o_dsp_inmode     = 5'b00000;
    assign o_dsp_carryinsel = 3'b000;
    // Enables are masked during reset so a reset right after a transfer leaves the slice untouched
    assign o_dsp_cea2       = r_vld[0] & ~i_rst;
    assign o_dsp_ceb2       = r_vld[0] & ~i_rst;
    assign o_dsp_cem        = r_vld[1] & ~i_rst;
    assign o_dsp_cectrl     = r_vld[1] & ~i_rst;
    assign o_dsp_cep        = r_vld[2] & ~i_rst;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: a behavioural DSP slice model closes the loop,
// a table of vectors drives the main function and hand-written sequences cover
// backpressure and mid-vector reset. Results go through a scoreboard queue.
module tb_dsp_mac_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sValid = 1'b0;
    logic        sReady;
    logic [24:0] sA = '0;
    logic [17:0] sB = '0;
    logic        sLast = 1'b0;
    logic        mValid;
    logic        mReady = 1'b1;
    logic [47:0] mData;
    logic [15:0] mCount;
    logic [29:0] dspA;
    logic [17:0] dspB;
    logic [6:0]  dspOpmode;
    logic [3:0]  dspAlumode;
    logic [4:0]  dspInmode;
    logic [2:0]  dspCarryinsel;
    logic        dspCea2, dspCeb2, dspCem, dspCectrl, dspCep;
    logic [47:0] dspP;

    dsp_mac_sequencer #(.CNT_W(16)) dut (
        .i_clk(clock), .i_rst(reset),
        .i_s_valid(sValid), .o_s_ready(sReady), .i_s_a(sA), .i_s_b(sB), .i_s_last(sLast),
        .o_m_valid(mValid), .i_m_ready(mReady), .o_m_data(mData), .o_m_count(mCount),
        .o_dsp_a(dspA), .o_dsp_b(dspB), .o_dsp_opmode(dspOpmode), .o_dsp_alumode(dspAlumode),
        .o_dsp_inmode(dspInmode), .o_dsp_carryinsel(dspCarryinsel),
        .o_dsp_cea2(dspCea2), .o_dsp_ceb2(dspCeb2), .o_dsp_cem(dspCem),
        .o_dsp_cectrl(dspCectrl), .o_dsp_cep(dspCep), .i_dsp_p(dspP)
    );

    always #5 clock = ~clock;

    // Behavioural slice: A2/B2, M, OPMODE and P registers, reset from top-level reset
    logic signed [29:0] slA;
    logic signed [17:0] slB;
    logic signed [47:0] slM, slP;
    logic [6:0]         slOpm;
    always @(posedge clock) begin
        if (reset) begin
            slA <= '0; slB <= '0; slM <= '0; slP <= '0; slOpm <= '0;
        end else begin
            if (dspCea2) slA <= dspA;
            if (dspCeb2) slB <= dspB;
            if (dspCem) slM <= slA * slB;
            if (dspCectrl) slOpm <= dspOpmode;
            if (dspCep) slP <= ((slOpm[6:4] == 3'b010) ? slP : 48'sd0)
                             + ((slOpm[3:0] == 4'b0101) ? slM : 48'sd0);
        end
    end
    assign dspP = slP;

    typedef struct packed {
        logic [47:0] d;
        logic [15:0] c;
    } res_t;

    typedef struct packed {
        logic [3:0][24:0] a;
        logic [3:0][17:0] b;
        logic [2:0]       n;
        logic             gaps;
        logic [47:0]      expData;
        logic [15:0]      expCount;
    } vec_t;

    res_t        expQ[$];
    res_t        gotQ[$];
    logic [6:0]  opLog[$];
    logic [29:0] aLog[$];
    logic [17:0] bLog[$];
    int          cepCount = 0;
    int          ceCount = 0;
    int          gotIdx = 0;
    int          checks = 0;
    int          fails = 0;
    vec_t        vecs[4];

    // Observer: records handshaken results, OPMODE/operand loads and enable pulses
    always @(negedge clock) begin
        if (!reset && mValid && mReady) gotQ.push_back({mData, mCount});
        if (dspCectrl) opLog.push_back(dspOpmode);
        if (dspCea2) aLog.push_back(dspA);
        if (dspCeb2) bLog.push_back(dspB);
        if (dspCep) cepCount <= cepCount + 1;
        if (dspCea2 | dspCeb2 | dspCem | dspCectrl | dspCep) ceCount <= ceCount + 1;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one pair from posedge+1, waits (bounded) for ready, returns just after the transfer edge
    task automatic applyStimulus(input logic [24:0] a, input logic [17:0] b, input logic last);
        bit ok = 0;
        sValid = 1'b1; sA = a; sB = b; sLast = last;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (sReady) begin ok = 1; break; end
        end
        checkOutput("input_accepted", 64'(ok), 1);
        @(posedge clock);
        #1 sValid = 1'b0;
    endtask

    task automatic waitIdle();
        bit ok = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clock);
            if (sReady && !mValid) begin ok = 1; break; end
        end
        checkOutput("idle_reached", 64'(ok), 1);
        @(posedge clock);
        #1;
    endtask

    task automatic drainScoreboard();
        res_t got, exp;
        while (gotIdx < gotQ.size()) begin
            got = gotQ[gotIdx];
            gotIdx++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_result", 1, 0);
            end else begin
                exp = expQ.pop_front();
                checkOutput("result_data", got.d, exp.d);
                checkOutput("result_count", 64'(got.c), 64'(exp.c));
            end
        end
        checkOutput("results_outstanding", 64'(expQ.size()), 0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_m_valid"}, 64'(mValid), 0);
        checkOutput({tag, "_m_data"}, mData, 0);
        checkOutput({tag, "_m_count"}, 64'(mCount), 0);
        checkOutput({tag, "_dsp_a"}, 64'(dspA), 0);
        checkOutput({tag, "_dsp_b"}, 64'(dspB), 0);
        checkOutput({tag, "_dsp_opmode"}, 64'(dspOpmode), 0);
        checkOutput({tag, "_ce"}, 64'({dspCea2, dspCeb2, dspCem, dspCectrl, dspCep}), 0);
        checkOutput({tag, "_consts"}, 64'({dspAlumode, dspInmode, dspCarryinsel}), 0);
        checkOutput({tag, "_s_ready"}, 64'(sReady), 1);
    endtask

    initial begin
        int opBase, aBase, cepBase, ceBase;
        logic [24:0] av;
        bit ok;

        vecs[0].a = {25'd0, 25'd7, -25'sd4, 25'd2};
        vecs[0].b = {18'd0, -18'sd1, 18'd5, 18'd3};
        vecs[0].n = 3; vecs[0].gaps = 0;
        vecs[0].expData = 48'hFFFF_FFFF_FFEB; vecs[0].expCount = 3;
        vecs[1].a = {25'd0, 25'd0, 25'd0, 25'h100_0000};
        vecs[1].b = {18'd0, 18'd0, 18'd0, 18'h2_0000};
        vecs[1].n = 1; vecs[1].gaps = 0;
        vecs[1].expData = 48'h0200_0000_0000; vecs[1].expCount = 1;
        vecs[2].a = {25'd1, 25'd1, 25'd1, 25'd1};
        vecs[2].b = {18'd1, 18'd1, 18'd1, 18'd1};
        vecs[2].n = 4; vecs[2].gaps = 1;
        vecs[2].expData = 48'd4; vecs[2].expCount = 4;
        vecs[3].a = {25'd0, 25'd0, -25'sd50, 25'd100};
        vecs[3].b = {18'd0, 18'd0, -18'sd3, -18'sd200};
        vecs[3].n = 2; vecs[3].gaps = 0;
        vecs[3].expData = 48'hFFFF_FFFF_B276; vecs[3].expCount = 2;

        // Power-on reset
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("ready_in_reset", 64'(sReady), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checkResetValues("por");
        @(posedge clock);
        #1;

        // Table-driven vectors, each followed by latency, enable and OPMODE checks
        for (int v = 0; v < 4; v++) begin
            opBase = opLog.size();
            aBase = aLog.size();
            cepBase = cepCount;
            for (int i = 0; i < int'(vecs[v].n); i++) begin
                applyStimulus(vecs[v].a[i], vecs[v].b[i], (i == int'(vecs[v].n) - 1));
                if (vecs[v].gaps && i < int'(vecs[v].n) - 1) begin
                    @(posedge clock);
                    #1;
                end
            end
            expQ.push_back({vecs[v].expData, vecs[v].expCount});
            for (int k = 0; k < 4; k++) begin
                @(negedge clock);
                checkOutput("drain_valid_low", 64'(mValid), 0);
                checkOutput("drain_ready_low", 64'(sReady), 0);
            end
            @(negedge clock);
            checkOutput("valid_at_t5", 64'(mValid), 1);
            waitIdle();
            drainScoreboard();
            checkOutput("cep_pulses", 64'(cepCount - cepBase), 64'(vecs[v].n));
            for (int i = 0; i < int'(vecs[v].n); i++) begin
                av = vecs[v].a[i];
                checkOutput("opmode_seq", 64'(opLog[opBase + i]), (i == 0) ? 64'h05 : 64'h25);
                checkOutput("dsp_a_signext", 64'(aLog[aBase + i]), 64'({{5{av[24]}}, av}));
                checkOutput("dsp_b", 64'(bLog[aBase + i]), 64'(vecs[v].b[i]));
            end
        end

        // Backpressure: result held stable while the consumer stalls
        mReady = 1'b0;
        applyStimulus(25'h1FF_FFFF, 18'd1, 1'b1);
        expQ.push_back({48'hFFFF_FFFF_FFFF, 16'd1});
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (mValid) begin ok = 1; break; end
        end
        checkOutput("stall_valid_seen", 64'(ok), 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            checkOutput("stall_valid", 64'(mValid), 1);
            checkOutput("stall_data", mData, 48'hFFFF_FFFF_FFFF);
            checkOutput("stall_count", 64'(mCount), 1);
            checkOutput("stall_ready", 64'(sReady), 0);
        end
        @(posedge clock);
        #1 mReady = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checkOutput("release_valid_low", 64'(mValid), 0);
        checkOutput("release_ready_high", 64'(sReady), 1);
        checkOutput("release_data_held", mData, 48'hFFFF_FFFF_FFFF);
        drainScoreboard();
        @(posedge clock);
        #1;
        applyStimulus(25'd5, 18'd5, 1'b1);
        expQ.push_back({48'd25, 16'd1});
        waitIdle();
        drainScoreboard();

        // Reset in the cycle after the second of two pending samples
        applyStimulus(25'd3, 18'd3, 1'b0);
        applyStimulus(25'd3, 18'd3, 1'b0);
        ceBase = ceCount;
        reset = 1'b1;
        @(negedge clock);
        checkOutput("reset_ce_masked", 64'({dspCea2, dspCeb2, dspCem, dspCectrl, dspCep}), 0);
        checkOutput("reset_ready_low", 64'(sReady), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checkResetValues("midrst");
        repeat (4) @(negedge clock);
        checkOutput("reset_no_ce", 64'(ceCount - ceBase), 0);
        checkOutput("reset_no_result", 64'(mValid), 0);
        @(posedge clock);
        #1;
        applyStimulus(25'd3, 18'd3, 1'b1);
        expQ.push_back({48'd9, 16'd1});
        waitIdle();
        drainScoreboard();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time bound exceeded");
    end

endmodule
